// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and the canonical NOP encoding.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage feeding decode from an external synchronous ROM.
// Define FETCH_MISALIGN_TRAP_EN to freeze fetch on a misaligned redirect target.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  output logic               misalign_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  rd_pc_q, rd_pc_d;      // byte address of the word currently on imem_rdata
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic         valid_q, valid_d;
  logic [31:0]  hold_q, hold_d;
  logic         hold_vld_q, hold_vld_d;

  logic         trapped;
  logic         trap_hit;
  logic [31:0]  target_pc;

  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic err_q;

  assign trap_hit = redirect && (redirect_pc[1:0] != 2'b00);
  assign trapped  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (trap_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign trap_hit = 1'b0;
  assign trapped  = 1'b0;
`endif

  assign misalign_err = trapped;
  assign imem_addr    = pc_q[IMEM_AW+1:2];
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_pc_d    = rd_pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;

    if (trapped || trap_hit) begin
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      hold_vld_d = 1'b0;
    end else if (redirect) begin
      pc_d       = target_pc;
      state_d    = BUBBLE;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      hold_vld_d = 1'b0;
    end else if (stall) begin
      // The ROM re-reads the held address, so park the word that was on the bus.
      if (state_q == RUN && !hold_vld_q) begin
        hold_d     = imem_rdata;
        hold_vld_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        BOOT, BUBBLE: begin
          state_d = RUN;
          pc_d    = pc_q + 32'd4;
          rd_pc_d = pc_q;
        end
        RUN: begin
          instr_d    = hold_vld_q ? hold_q : imem_rdata;
          instr_pc_d = rd_pc_q;
          valid_d    = 1'b1;
          hold_vld_d = 1'b0;
          pc_d       = pc_q + 32'd4;
          rd_pc_d    = pc_q;
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      rd_pc_q    <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
      valid_q    <= 1'b0;
      hold_q     <= 32'h0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_pc_q    <= rd_pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected fetch addresses are queued as stimulus
// is applied and popped whenever the DUT presents a valid instruction.
module tb_instr_fetch;
  import cpu_pkg::*;

  localparam int unsigned   IMEM_AW  = 12;
  localparam logic [31:0]   RESET_PC = 32'h0000_0000;
  localparam logic [11:0]   RST_WORD = 12'(RESET_PC >> 2);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               stall = 1'b0;
  logic               redirect = 1'b0;
  logic [31:0]        redirect_pc = 32'h0;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata = 32'h0;
  logic [31:0]        instr;
  logic [31:0]        instr_pc;
  logic               instr_valid;
  logic               misalign_err;

  int tests_run = 0;
  int failed    = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_instr = NOP_INSTR;
  logic [31:0] last_pc    = RESET_PC;
  logic        last_valid = 1'b0;

  instr_fetch #(
    .RESET_PC(RESET_PC),
    .IMEM_AW (IMEM_AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_f(input logic [11:0] a);
    return {8'hA5, 4'h0, a, 8'h3C};
  endfunction

  always @(posedge clk) imem_rdata <= rom_f(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One clock; classify the edge by the inputs that were applied to it.
  task automatic tick();
    logic        st, rd, rs;
    logic [31:0] epc;
    st = stall;
    rd = redirect;
    rs = rst;
    @(posedge clk);
    #1;
    if (rs) begin
      check("rst_instr", instr, NOP_INSTR);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr_pc", instr_pc, RESET_PC);
      check("rst_imem_addr", 32'(imem_addr), 32'(RST_WORD));
      check("rst_misalign", 32'(misalign_err), 32'd0);
      last_valid = 1'b0;
      last_instr = NOP_INSTR;
    end else if (st && !rd) begin
      check("stall_valid", 32'(instr_valid), 32'(last_valid));
      check("stall_instr", instr, last_instr);
      if (last_valid) check("stall_instr_pc", instr_pc, last_pc);
    end else if (instr_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_valid", 32'(instr_valid), 32'd0);
      end else begin
        epc = exp_q.pop_front();
        check("instr", instr, rom_f(epc[13:2]));
        check("instr_pc", instr_pc, epc);
        last_valid = 1'b1;
        last_instr = rom_f(epc[13:2]);
        last_pc    = epc;
      end
    end else begin
      check("bubble_nop", instr, NOP_INSTR);
      last_valid = 1'b0;
      last_instr = NOP_INSTR;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string tag);
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    stall    = 1'b0;
    redirect = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  initial begin
    // Straight-line fetch of A..D
    do_reset();
    push_run(32'h0, 4);
    ticks(5);
    drain("s1_drain");

    // Stall while B is presented; C and D follow with nothing lost
    do_reset();
    push_run(32'h0, 4);
    ticks(3);
    stall = 1'b1;
    ticks(3);
    stall = 1'b0;
    ticks(2);
    drain("s2_drain");

    // Redirect to 0x40 while B is presented
    do_reset();
    push_run(32'h0, 2);
    ticks(3);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    push_run(32'h40, 2);
    tick();
    redirect = 1'b0;
    ticks(3);
    drain("s3_drain");

    // Redirect beats stall, re-redirect inside BUBBLE, stall inside BUBBLE
    do_reset();
    push_run(32'h0, 2);
    ticks(3);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    stall       = 1'b0;
    redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    stall    = 1'b1;
    ticks(2);
    stall = 1'b0;
    push_run(32'h80, 2);
    ticks(3);
    drain("s4_drain");

    // Reset in the middle of a stall, then fetch restarts from A
    do_reset();
    push_run(32'h0, 2);
    ticks(3);
    stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    stall = 1'b0;
    push_run(32'h0, 2);
    ticks(3);
    drain("s5_drain");

    // Misaligned redirect target
    do_reset();
    push_run(32'h0, 1);
    ticks(2);
    redirect    = 1'b1;
    redirect_pc = 32'h42;
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("misalign_sticky", 32'(misalign_err), 32'd1);
      check("misalign_valid", 32'(instr_valid), 32'd0);
    end
    drain("s6_drain");
    do_reset();
`else
    push_run(32'h40, 2);
    tick();
    redirect = 1'b0;
    ticks(3);
    check("misalign_tied", 32'(misalign_err), 32'd0);
    drain("s6_drain");
`endif

    // PC wraps from 0xFFFF_FFFC to 0
    do_reset();
    push_run(32'h0, 1);
    ticks(2);
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0004);
    tick();
    redirect = 1'b0;
    ticks(5);
    drain("s7_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 SHALL have parameter IMEM_AW, default 12, meaning instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  hold PC and outputs this cycle.
REQ-006 SHALL have port redirect  input  1  jump/branch taken, load redirect_pc.
REQ-007 SHALL have port redirect_pc  input  32  target byte address.
REQ-008 SHALL have port imem_addr  output  IMEM_AW  word address to synchronous ROM (pc[IMEM_AW+1:2]).
REQ-009 SHALL have port imem_rdata  input  32  ROM data, valid one cycle after imem_addr.
REQ-010 SHALL have port instr  output  32  instruction word presented to the decode/control unit.
REQ-011 SHALL have port instr_pc  output  32  byte address of instr.
REQ-012 SHALL have port instr_valid  output  1  instr is a real fetched instruction, not a bubble.
REQ-013 SHALL have port misalign_err  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-014 SHALL implement FSM states BOOT, RUN, BUBBLE.
REQ-015 BOOT: entered on reset; imem_addr = RESET_PC word; next cycle -> RUN with first instruction valid.
REQ-016 RUN, no stall, no redirect: pc <= pc+4 (32-bit wrap 0xFFFF_FFFC -> 0), instr <= imem_rdata, instr_pc <= previous pc, instr_valid <= 1.
REQ-017 Fetch latency SHALL be exactly one cycle from imem_addr to instr update.
REQ-018 stall=1 (no redirect): pc, instr, instr_pc, instr_valid, imem_addr all held; imem_rdata captured into a one-entry hold register so no word is lost when stall deasserts.
REQ-019 redirect=1: pc <= redirect_pc, state -> BUBBLE, in-flight word discarded, instr <= 32'h0000_0013 (NOP), instr_valid <= 0.
REQ-020 redirect SHALL take priority over stall in the same cycle.
REQ-021 BUBBLE: one cycle with instr_valid=0, then RUN presenting the word at redirect_pc.
REQ-022 redirect during BUBBLE SHALL restart BUBBLE with the new target; the older target is never presented.
REQ-023 stall during BUBBLE SHALL keep state BUBBLE and instr_valid=0 until stall drops.
REQ-024 instr SHALL equal NOP whenever instr_valid=0.

Reset
REQ-025 rst=1 at any clock edge, including mid-stall or mid-BUBBLE: pc <= RESET_PC, state <= BOOT, instr <= NOP, instr_pc <= RESET_PC, instr_valid <= 0, hold register cleared, misalign_err <= 0.
REQ-026 rst SHALL override stall and redirect.

Configuration
REQ-027 Macro FETCH_MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0] != 0 sets misalign_err (sticky until rst), pc frozen, instr_valid held 0 thereafter.
REQ-028 Macro undefined: redirect_pc[1:0] ignored (forced 0), misalign_err tied 0, no extra state.

Structure
REQ-029 Shared package cpu_pkg SHALL hold NOP_INSTR (32'h0000_0013) and fetch_state_t enum {BOOT, RUN, BUBBLE}.
REQ-030 SHALL be a single module, no sub-modules; ROM lives outside.

Verification
REQ-031 Reset, ROM words 0..3 = A,B,C,D, no stall -> instr A,B,C,D on cycles 2..5, instr_pc 0,4,8,12, instr_valid 1.
REQ-032 stall held 3 cycles while instr=B -> instr B, instr_pc 4 held; after release next is C, no word lost or repeated.
REQ-033 redirect to 0x40 while instr=B -> next cycle NOP with instr_valid=0, then word at 0x40 with instr_pc 0x40.
REQ-034 redirect and stall together -> redirect wins, BUBBLE entered; redirect again during BUBBLE to 0x80 -> 0x40 word never valid, 0x80 presented.
REQ-035 rst asserted mid-stall -> next cycle instr=NOP, instr_valid=0, imem_addr=RESET_PC word; fetch resumes from A.
REQ-036 With FETCH_MISALIGN_TRAP_EN, redirect to 0x42 -> misalign_err=1 sticky, instr_valid=0 until rst; without macro, fetch proceeds from 0x40.
